// File: rtl/fifo_frame_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_frame_reader_if
//  Description : Handshake bundle for fifo_frame_reader. Carries the start
//                pulse, the FIFO-side valid/ready/data, the framed output
//                stream with its flags and indices, and busy/done status.
//                The master modport is the reader itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fifo_frame_reader_if #(
    parameter int WIDTH_P = 8,
    parameter int COLS_P  = 640,
    parameter int ROWS_P  = 480
);
    localparam int C_COL_W = (COLS_P > 1) ? $clog2(COLS_P) : 1;
    localparam int C_ROW_W = (ROWS_P > 1) ? $clog2(ROWS_P) : 1;

    logic               start_i;
    logic               valid_i;
    logic [WIDTH_P-1:0] data_i;
    logic               ready_o;
    logic               valid_o;
    logic [WIDTH_P-1:0] data_o;
    logic               sof_o;
    logic               eol_o;
    logic               eof_o;
    logic [C_COL_W-1:0] col_o;
    logic [C_ROW_W-1:0] row_o;
    logic               ready_i;
    logic               busy_o;
    logic               done_o;

    modport master (
        input  start_i, valid_i, data_i, ready_i,
        output ready_o, valid_o, data_o, sof_o, eol_o, eof_o,
               col_o, row_o, busy_o, done_o
    );

    modport slave (
        output start_i, valid_i, data_i, ready_i,
        input  ready_o, valid_o, data_o, sof_o, eol_o, eof_o,
               col_o, row_o, busy_o, done_o
    );
endinterface
`default_nettype wire

// File: rtl/fifo_frame_reader.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_frame_reader
//  Description : Pulls exactly COLS_P x ROWS_P words from a FIFO after a start
//                pulse, tags each with sof/eol/eof and col/row indices, and
//                emits them through a registered output stage. done_o pulses
//                once the eof word has left the block.
//  Options     : FRAME_READER_SKID_EN - 2-entry skid output stage with a
//                registered ready_o; otherwise a single output register with
//                ready_o combinational from ready_i.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_frame_reader #(
    parameter int WIDTH_P = 8,
    parameter int COLS_P  = 640,
    parameter int ROWS_P  = 480
) (
    input  wire logic             clk_i,
    input  wire logic             rst_i,
    fifo_frame_reader_if.master   bus
);
    localparam int C_COL_W = (COLS_P > 1) ? $clog2(COLS_P) : 1;
    localparam int C_ROW_W = (ROWS_P > 1) ? $clog2(ROWS_P) : 1;
    localparam logic [C_COL_W-1:0] C_COL_LAST = C_COL_W'(COLS_P - 1);
    localparam logic [C_ROW_W-1:0] C_ROW_LAST = C_ROW_W'(ROWS_P - 1);

    typedef struct packed {
        logic [WIDTH_P-1:0] data;
        logic               sof;
        logic               eol;
        logic               eof;
        logic [C_COL_W-1:0] col;
        logic [C_ROW_W-1:0] row;
    } word_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             state_q;
    logic [C_COL_W-1:0] col_q;
    logic [C_ROW_W-1:0] row_q;
    word_t              head_q;     // word presented on the outputs
    logic [1:0]         count_q;    // words held in the output stage
    logic               valid_q;
    logic               done_q;
`ifdef FRAME_READER_SKID_EN
    word_t              skid_q;     // second word, caught while head stalls
    logic               ready_q;
`endif

    word_t      in_word;
    logic       ready;
    logic       in_fire;
    logic       out_fire;
    logic       last_in;
    logic       run_next;
    logic [1:0] count_d;

    // Tag the word currently offered by the FIFO from the position counters
    always_comb begin
        in_word.data = bus.data_i;
        in_word.sof  = (col_q == '0) && (row_q == '0);
        in_word.eol  = (col_q == C_COL_LAST);
        in_word.eof  = (col_q == C_COL_LAST) && (row_q == C_ROW_LAST);
        in_word.col  = col_q;
        in_word.row  = row_q;
    end

    // Handshakes, output-stage occupancy and next-cycle RUN indication
    always_comb begin
`ifdef FRAME_READER_SKID_EN
        ready    = ready_q;
`else
        // Leaving RUN on the last transfer is what stops further accepts
        ready    = (state_q == S_RUN) && (!valid_q || bus.ready_i);
`endif
        in_fire  = bus.valid_i && ready;
        out_fire = valid_q && bus.ready_i;
        last_in  = in_fire && in_word.eof;
        count_d  = count_q + 2'(in_fire) - 2'(out_fire);
        run_next = ((state_q == S_IDLE) && bus.start_i) ||
                   ((state_q == S_RUN) && !last_in);
    end

    // Frame FSM, position counters and output stage
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            head_q  <= '0;
            count_q <= 2'd0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
`ifdef FRAME_READER_SKID_EN
            skid_q  <= '0;
            ready_q <= 1'b0;
`endif
        end else begin
            done_q  <= 1'b0;
            count_q <= count_d;
            valid_q <= (count_d != 2'd0);

            case (state_q)
                S_IDLE: begin
                    if (bus.start_i) begin
                        state_q <= S_RUN;
                        col_q   <= '0;
                        row_q   <= '0;
                    end
                end
                S_RUN: begin
                    if (in_fire) begin
                        if (col_q == C_COL_LAST) begin
                            col_q <= '0;
                            row_q <= (row_q == C_ROW_LAST) ? '0 : row_q + 1'b1;
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                        if (last_in) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // No more input arrives here, so an empty stage means
                    // the eof word just left
                    if (out_fire && (count_d == 2'd0)) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

`ifdef FRAME_READER_SKID_EN
            if (out_fire && (count_q == 2'd2)) begin
                head_q <= skid_q;
            end
            if (in_fire) begin
                if ((count_q == 2'd0) || ((count_q == 2'd1) && out_fire)) begin
                    head_q <= in_word;
                end else begin
                    skid_q <= in_word;
                end
            end
            // One more word may land next cycle only if a slot stays free
            ready_q <= run_next && (count_d != 2'd2);
`else
            if (in_fire) begin
                head_q <= in_word;
            end
`endif
        end
    end

    assign bus.ready_o = ready;
    assign bus.valid_o = valid_q;
    assign bus.data_o  = head_q.data;
    assign bus.sof_o   = head_q.sof;
    assign bus.eol_o   = head_q.eol;
    assign bus.eof_o   = head_q.eof;
    assign bus.col_o   = head_q.col;
    assign bus.row_o   = head_q.row;
    assign bus.busy_o  = (state_q != S_IDLE);
    assign bus.done_o  = done_q;

`ifndef FRAME_READER_SKID_EN
    // run_next only feeds the registered ready of the skid variant
    logic unused_run_next;
    assign unused_run_next = run_next;
`endif
endmodule
`default_nettype wire
